// File: rtl/ysyx_22040632_regread_issue.sv
// ysyx_22040632_regread_issue
//   Register-read / issue stage between decode and EX. Owns the GPR file,
//   tracks long-latency producers (load/div) in a per-register scoreboard,
//   bypasses same-cycle writebacks into the operands and holds the ID/EX
//   payload in a single output register with valid/ready handshakes.
//   Optional: YSYX_22040632_DIFFTEST_EN adds regs_o (GPR snapshot with
//   write-through) and issue_cnt (64-bit retire counter).
module ysyx_22040632_regread_issue #(
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int WB_PORTS = 2,
    localparam int RW      = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     rrst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    input  logic [RW-1:0]            in_rs1,
    input  logic [RW-1:0]            in_rs2,
    input  logic                     in_use1,
    input  logic                     in_use2,
    input  logic [RW-1:0]            in_rd,
    input  logic                     in_rd_wen,
    input  logic                     in_long,
    input  logic [WB_PORTS-1:0]      wb_valid,
    input  logic [WB_PORTS*RW-1:0]   wb_rd,
    input  logic [WB_PORTS*XLEN-1:0] wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    output logic [RW-1:0]            out_rd,
    output logic                     out_rd_wen,
    output logic [XLEN-1:0]          out_src1,
    output logic [XLEN-1:0]          out_src2
`ifdef YSYX_22040632_DIFFTEST_EN
   ,output logic [NREG*XLEN-1:0]     regs_o,
    output logic [63:0]              issue_cnt
`endif
);

    localparam int KW = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;

    logic [XLEN-1:0] gpr [NREG];
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_nxt;
    logic [NREG-1:0] wbhit;
    logic [RW-1:0]   wb_rd_a   [WB_PORTS];
    logic [XLEN-1:0] wb_data_a [WB_PORTS];
    logic [XLEN-1:0] src1_byp;
    logic [XLEN-1:0] src2_byp;
    logic            hazard;
    logic            accept;
    logic            out_long;

    for (genvar g = 0; g < WB_PORTS; g++) begin : g_wb_unpack
        assign wb_rd_a[g]   = wb_rd[g*RW +: RW];
        assign wb_data_a[g] = wb_data[g*XLEN +: XLEN];
    end

    // Operand read with write-through from the highest-indexed matching WB port
    always_comb begin
        src1_byp = gpr[in_rs1];
        src2_byp = gpr[in_rs2];
        wbhit    = '0;
        for (int unsigned k = 0; k < WB_PORTS; k++) begin
            if (wb_valid[KW'(k)]) begin
                wbhit[wb_rd_a[KW'(k)]] = 1'b1;
                if (wb_rd_a[KW'(k)] == in_rs1) src1_byp = wb_data_a[KW'(k)];
                if (wb_rd_a[KW'(k)] == in_rs2) src2_byp = wb_data_a[KW'(k)];
            end
        end
        if (in_rs1 == '0) src1_byp = '0;
        if (in_rs2 == '0) src2_byp = '0;
    end

    assign hazard = (in_use1   && sb[in_rs1] && !wbhit[in_rs1])
                  | (in_use2   && sb[in_rs2] && !wbhit[in_rs2])
                  | (in_rd_wen && sb[in_rd]  && !wbhit[in_rd]);

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Scoreboard update: WB clears, flushed long entry clears, accept sets last so set wins
    always_comb begin
        sb_nxt = sb;
        for (int unsigned k = 0; k < WB_PORTS; k++) begin
            if (wb_valid[KW'(k)]) sb_nxt[wb_rd_a[KW'(k)]] = 1'b0;
        end
        if (flush && out_valid && out_long) sb_nxt[out_rd] = 1'b0;
        if (accept && in_long && in_rd_wen && (in_rd != '0)) sb_nxt[in_rd] = 1'b1;
        sb_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) sb <= '0;
        else         sb <= sb_nxt;
    end

    // GPR file: later ports are assigned later, so the highest index wins on collisions
    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int unsigned i = 0; i < NREG; i++) gpr[RW'(i)] <= '0;
        end else begin
            for (int unsigned k = 0; k < WB_PORTS; k++) begin
                if (wb_valid[KW'(k)] && (wb_rd_a[KW'(k)] != '0))
                    gpr[wb_rd_a[KW'(k)]] <= wb_data_a[KW'(k)];
            end
        end
    end

    // ID/EX payload register: flush kills, accept loads, consume drains, otherwise hold
    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_inst   <= '0;
            out_rd     <= '0;
            out_rd_wen <= 1'b0;
            out_src1   <= '0;
            out_src2   <= '0;
            out_long   <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_long   <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_pc     <= in_pc;
            out_inst   <= in_inst;
            out_rd     <= in_rd;
            out_rd_wen <= in_rd_wen;
            out_src1   <= in_use1 ? src1_byp : '0;
            out_src2   <= in_use2 ? src2_byp : '0;
            out_long   <= in_long && in_rd_wen && (in_rd != '0);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
            out_long   <= 1'b0;
        end
    end

`ifdef YSYX_22040632_DIFFTEST_EN
    // GPR snapshot including this cycle's writebacks
    always_comb begin
        regs_o = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            regs_o[r*XLEN +: XLEN] = gpr[RW'(r)];
            for (int unsigned k = 0; k < WB_PORTS; k++) begin
                if (wb_valid[KW'(k)] && (wb_rd_a[KW'(k)] == RW'(r)))
                    regs_o[r*XLEN +: XLEN] = wb_data_a[KW'(k)];
            end
        end
    end

    // Retire counter: one count per payload handed to EX
    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n)                    issue_cnt <= '0;
        else if (out_valid && out_ready) issue_cnt <= issue_cnt + 64'd1;
    end
`endif

endmodule

// File: tb/tb_ysyx_22040632_regread_issue.sv
// tb_ysyx_22040632_regread_issue
//   Directed scenarios with a payload scoreboard: expected EX payloads are
//   queued when an accept is driven and compared by a negedge monitor
//   whenever the DUT presents out_valid.
module tb_ysyx_22040632_regread_issue;

    logic        clk = 1'b0;
    logic        rrst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic        in_use1 = 1'b0;
    logic        in_use2 = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        in_rd_wen = 1'b0;
    logic        in_long = 1'b0;
    logic [1:0]  wb_valid = '0;
    logic [9:0]  wb_rd = '0;
    logic [127:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic [63:0] out_src1;
    logic [63:0] out_src2;
`ifdef YSYX_22040632_DIFFTEST_EN
    logic [2047:0] regs_o;
    logic [63:0]   issue_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] s1;
        logic [63:0] s2;
    } exp_t;

    exp_t exp_q[$];

    ysyx_22040632_regread_issue #(.XLEN(64), .NREG(32), .WB_PORTS(2)) dut (
        .clk        (clk),
        .rrst_n     (rrst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_use1    (in_use1),
        .in_use2    (in_use2),
        .in_rd      (in_rd),
        .in_rd_wen  (in_rd_wen),
        .in_long    (in_long),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_rd     (out_rd),
        .out_rd_wen (out_rd_wen),
        .out_src1   (out_src1),
        .out_src2   (out_src2)
`ifdef YSYX_22040632_DIFFTEST_EN
       ,.regs_o     (regs_o),
        .issue_cnt  (issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every presented payload must match the queue head
    always @(negedge clk) begin
        if (rrst_n && out_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected out_pc=%h with no queued payload", out_pc);
            end else begin
                if (out_pc !== exp_q[0].pc || out_inst !== ~exp_q[0].pc ||
                    out_rd !== exp_q[0].rd || out_rd_wen !== exp_q[0].wen ||
                    out_src1 !== exp_q[0].s1 || out_src2 !== exp_q[0].s2) begin
                    bad++;
                    $display("FAIL sb_payload got pc=%h inst=%h rd=%0d wen=%b s1=%h s2=%h want pc=%h rd=%0d wen=%b s1=%h s2=%h",
                             out_pc, out_inst, out_rd, out_rd_wen, out_src1, out_src2,
                             exp_q[0].pc, exp_q[0].rd, exp_q[0].wen, exp_q[0].s1, exp_q[0].s2);
                end
                if (out_ready || flush) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_use1  = 1'b0;
        in_use2  = 1'b0;
        in_rd_wen = 1'b0;
        in_long  = 1'b0;
        wb_valid = '0;
        flush    = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic drive_inst(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic wen, input logic lng);
        in_valid  = 1'b1;
        in_pc     = pc;
        in_inst   = ~pc;
        in_rs1    = rs1;
        in_use1   = u1;
        in_rs2    = rs2;
        in_use2   = u2;
        in_rd     = rd;
        in_rd_wen = wen;
        in_long   = lng;
    endtask

    task automatic set_wb(input int port, input logic [4:0] rd, input logic [63:0] data);
        wb_valid[port]         = 1'b1;
        wb_rd[port*5 +: 5]     = rd;
        wb_data[port*64 +: 64] = data;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                            input logic [63:0] s1, input logic [63:0] s2);
        exp_t e;
        e.pc = pc; e.rd = rd; e.wen = wen; e.s1 = s1; e.s2 = s2;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || out_pc !== '0 || out_inst !== '0 || out_rd !== '0 ||
            out_rd_wen !== 1'b0 || out_src1 !== '0 || out_src2 !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b pc=%h inst=%h rd=%0d wen=%b s1=%h s2=%h want all 0",
                     out_valid, out_pc, out_inst, out_rd, out_rd_wen, out_src1, out_src2);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
`ifdef YSYX_22040632_DIFFTEST_EN
        total++;
        if (issue_cnt !== 64'd0) begin
            bad++;
            $display("FAIL reset_issue_cnt got %0d want 0", issue_cnt);
        end
`endif
        tick();
        tick();
        rrst_n = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        idle();
        set_wb(0, 5'd5, 64'h1234);
        tick();
        idle();
        set_wb(1, 5'd5, 64'hBEEF);
        drive_inst(32'h100, 5'd5, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bypass_ready got %b want 1", in_ready);
        end
        push_exp(32'h100, 5'd10, 1'b1, 64'hBEEF, 64'h0);
        tick();
        // x5 must now hold the port-1 value; rs2 unused gives 0
        idle();
        drive_inst(32'h104, 5'd5, 1'b1, 5'd5, 1'b0, 5'd11, 1'b1, 1'b0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bypass_b2b_ready got %b want 1", in_ready);
        end
        push_exp(32'h104, 5'd11, 1'b1, 64'hBEEF, 64'h0);
        tick();
        // two ports hit x6 in the same cycle: port 1 wins for bypass and write
        idle();
        set_wb(0, 5'd6, 64'h1111);
        set_wb(1, 5'd6, 64'h2222);
        drive_inst(32'h108, 5'd6, 1'b0, 5'd6, 1'b1, 5'd12, 1'b1, 1'b0);
        push_exp(32'h108, 5'd12, 1'b1, 64'h0, 64'h2222);
        tick();
        idle();
        drive_inst(32'h10C, 5'd6, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        push_exp(32'h10C, 5'd12, 1'b1, 64'h2222, 64'h0);
        tick();
        idle();
        tick();
        tick();
    endtask

    task automatic test_long_stall();
        idle();
        drive_inst(32'h200, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL long_accept_ready got %b want 1", in_ready);
        end
        push_exp(32'h200, 5'd7, 1'b1, 64'h0, 64'h0);
        tick();
        idle();
        drive_inst(32'h204, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            if (c == 1) set_wb(1, 5'd3, 64'h33);
            #1;
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL long_stall_ready cycle %0d got %b want 0", c, in_ready);
            end
            tick();
            wb_valid = '0;
        end
        set_wb(0, 5'd7, 64'h55);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL long_release_ready got %b want 1", in_ready);
        end
        push_exp(32'h204, 5'd8, 1'b1, 64'h55, 64'h0);
        tick();
        // sb[7] cleared: a new writer of x7 is not blocked
        idle();
        drive_inst(32'h208, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL long_sb_cleared_ready got %b want 1", in_ready);
        end
        push_exp(32'h208, 5'd7, 1'b1, 64'h0, 64'h0);
        tick();
        idle();
        tick();
    endtask

    task automatic test_hold();
        idle();
        out_ready = 1'b0;
        drive_inst(32'h300, 5'd5, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
        push_exp(32'h300, 5'd13, 1'b1, 64'hBEEF, 64'h0);
        tick();
        drive_inst(32'h304, 5'd6, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0);
        set_wb(0, 5'd5, 64'h999);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL hold_cycle %0d got in_ready=%b out_valid=%b want 0/1", c, in_ready, out_valid);
            end
            tick();
            wb_valid = '0;
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release_ready got %b want 1", in_ready);
        end
        push_exp(32'h304, 5'd15, 1'b1, 64'h2222, 64'h0);
        tick();
        idle();
        tick();
    endtask

    task automatic test_flush();
        idle();
        out_ready = 1'b0;
        drive_inst(32'h400, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        push_exp(32'h400, 5'd9, 1'b1, 64'h0, 64'h0);
        tick();
        flush = 1'b1;
        drive_inst(32'h404, 5'd0, 1'b0, 5'd0, 1'b0, 5'd17, 1'b1, 1'b0);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_ready got %b want 0", in_ready);
        end
        tick();
        idle();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_out_valid got %b want 0", out_valid);
        end
        drive_inst(32'h408, 5'd9, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_sb9_cleared got in_ready=%b want 1", in_ready);
        end
        push_exp(32'h408, 5'd16, 1'b1, 64'h0, 64'h0);
        tick();
        idle();
        tick();
    endtask

    task automatic test_x0();
        idle();
        set_wb(0, 5'd0, 64'hFF);
        drive_inst(32'h500, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
        push_exp(32'h500, 5'd0, 1'b1, 64'h0, 64'h0);
        tick();
        idle();
        drive_inst(32'h504, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL x0_no_sb got in_ready=%b want 1", in_ready);
        end
        push_exp(32'h504, 5'd0, 1'b1, 64'h0, 64'h0);
        tick();
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        out_ready = 1'b0;
        drive_inst(32'h600, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1);
        push_exp(32'h600, 5'd14, 1'b1, 64'h0, 64'h0);
        tick();
        drive_inst(32'h604, 5'd14, 1'b1, 5'd0, 1'b0, 5'd18, 1'b1, 1'b0);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_stall_ready got %b want 0", in_ready);
        end
        rrst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        #1;
        total++;
        if (out_valid !== 1'b0 || out_pc !== '0 || out_rd !== '0 || out_rd_wen !== 1'b0 ||
            out_src1 !== '0 || out_src2 !== '0 || out_inst !== '0) begin
            bad++;
            $display("FAIL rstmid_outputs got v=%b pc=%h rd=%0d wen=%b s1=%h want all 0",
                     out_valid, out_pc, out_rd, out_rd_wen, out_src1);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_in_ready got %b want 1", in_ready);
        end
`ifdef YSYX_22040632_DIFFTEST_EN
        total++;
        if (issue_cnt !== 64'd0) begin
            bad++;
            $display("FAIL rstmid_issue_cnt got %0d want 0", issue_cnt);
        end
`endif
        tick();
        rrst_n = 1'b1;
        // GPR x5 and sb[14] both cleared by reset
        drive_inst(32'h608, 5'd5, 1'b1, 5'd14, 1'b1, 5'd14, 1'b1, 1'b0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_post_ready got %b want 1", in_ready);
        end
        push_exp(32'h608, 5'd14, 1'b1, 64'h0, 64'h0);
        tick();
        idle();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_long_stall();
        test_hold();
        test_flush();
        test_x0();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got %0d payloads never presented want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
